// File: rtl/gravsim_pkg.sv
// Shared types for the planet renderer: planet slot record, geometry widths
// and the decoder for the Nios write word.
package gravsim_pkg;

   localparam int N_PLANETS_MAX = 8;
   localparam int COORD_W       = 10;
   localparam int PLANET_R_W    = 6;

   typedef struct packed {
      logic [COORD_W-1:0]    x;
      logic [COORD_W-1:0]    y;
      logic [PLANET_R_W-1:0] radius;
   } planet_t;

   // Bits [5:0] of the write word carry nothing, so only [31:6] is decoded.
   function automatic planet_t unpack_planet(input logic [31:6] w);
      planet_t p;
      p.x      = w[31:22];
      p.y      = w[21:12];
      p.radius = w[11:6];
      return p;
   endfunction

endpackage

// File: rtl/planet_hit_unit.sv
// Three-stage circle hit test for one planet slot; optional outline flag
// when PLANET_RING_EN is defined.
module planet_hit_unit
   import gravsim_pkg::*;
#(
   parameter int R_W = PLANET_R_W
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [COORD_W-1:0] draw_x_i,
   input  logic [COORD_W-1:0] draw_y_i,
   input  planet_t            planet_i,
   output logic               hit_o
`ifdef PLANET_RING_EN
   ,
   output logic               ring_o
`endif
);

   logic        [R_W-1:0]   radius_w;
   logic signed [10:0]      dx_p1_d, dy_p1_d, dx_p1_q, dy_p1_q;
   logic        [2*R_W-1:0] r2_p1_d, r2_p1_q, r2_p2_q;
   logic signed [21:0]      dx_ext, dy_ext;
   logic        [19:0]      dx2_p2_d, dy2_p2_d, dx2_p2_q, dy2_p2_q;
   logic        [20:0]      d2;
   logic                    hit_p3_d, hit_p3_q;
`ifdef PLANET_RING_EN
   logic        [R_W-1:0]   rad_p1_q, rad_p2_q;
   logic                    ring_p3_d, ring_p3_q;
`endif

   always_comb begin
      radius_w = R_W'(planet_i.radius);
      dx_p1_d  = $signed({1'b0, draw_x_i}) - $signed({1'b0, planet_i.x});
      dy_p1_d  = $signed({1'b0, draw_y_i}) - $signed({1'b0, planet_i.y});
      r2_p1_d  = (2*R_W)'(radius_w) * (2*R_W)'(radius_w);
      dx_ext   = 22'(dx_p1_q);
      dy_ext   = 22'(dy_p1_q);
      dx2_p2_d = 20'(dx_ext * dx_ext);
      dy2_p2_d = 20'(dy_ext * dy_ext);
      // Full 21-bit sum: two 20-bit squares can carry out.
      d2       = {1'b0, dx2_p2_q} + {1'b0, dy2_p2_q};
      hit_p3_d = (r2_p2_q != '0) && (d2 <= 21'(r2_p2_q));
`ifdef PLANET_RING_EN
      ring_p3_d = hit_p3_d && ((21'(r2_p2_q) - d2) < 21'({rad_p2_q, 1'b0}));
`endif
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         dx_p1_q  <= '0;
         dy_p1_q  <= '0;
         r2_p1_q  <= '0;
         dx2_p2_q <= '0;
         dy2_p2_q <= '0;
         r2_p2_q  <= '0;
         hit_p3_q <= 1'b0;
`ifdef PLANET_RING_EN
         rad_p1_q  <= '0;
         rad_p2_q  <= '0;
         ring_p3_q <= 1'b0;
`endif
      end else begin
         // S1: offsets and r^2 captured from the active table at one edge
         dx_p1_q  <= dx_p1_d;
         dy_p1_q  <= dy_p1_d;
         r2_p1_q  <= r2_p1_d;
         // S2: squares
         dx2_p2_q <= dx2_p2_d;
         dy2_p2_q <= dy2_p2_d;
         r2_p2_q  <= r2_p1_q;
         // S3: compare
         hit_p3_q <= hit_p3_d;
`ifdef PLANET_RING_EN
         rad_p1_q  <= radius_w;
         rad_p2_q  <= rad_p1_q;
         ring_p3_q <= ring_p3_d;
`endif
      end
   end

   assign hit_o = hit_p3_q;
`ifdef PLANET_RING_EN
   assign ring_o = ring_p3_q;
`endif

endmodule

// File: rtl/planet_renderer.sv
// Shadow/active planet tables with vsync commit and per-slot hit units feeding a
// lowest-index priority encoder. Define PLANET_RING_EN to add the is_ring output.
module planet_renderer
   import gravsim_pkg::*;
#(
   parameter int N_PLANETS = 4,
   parameter int R_W       = PLANET_R_W
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               wr_en,
   input  logic [2:0]         wr_idx,
   input  logic [31:0]        wr_data,
   input  logic               VGA_VS,
   input  logic [COORD_W-1:0] DrawX,
   input  logic [COORD_W-1:0] DrawY,
   output logic               is_ball,
   output logic [2:0]         planet_id,
   output logic               frame_tick
`ifdef PLANET_RING_EN
   ,
   output logic               is_ring
`endif
);

   planet_t shadow_d [N_PLANETS];
   planet_t shadow_q [N_PLANETS];
   planet_t active_d [N_PLANETS];
   planet_t active_q [N_PLANETS];
   logic    vs_q, commit, frame_tick_q;
   logic    unused_wr_bits;
   logic [N_PLANETS-1:0] hit;
`ifdef PLANET_RING_EN
   logic [N_PLANETS-1:0] ring;
`endif

   assign unused_wr_bits = ^wr_data[5:0];
   assign commit         = vs_q & ~VGA_VS;

   // Commit copies shadow_d, so a write landing on the commit edge is included.
   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      for (int i = 0; i < N_PLANETS; i++) begin
         if (wr_en && (wr_idx == 3'(i))) shadow_d[i] = unpack_planet(wr_data[31:6]);
      end
      if (commit) active_d = shadow_d;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         shadow_q     <= '{default: '0};
         active_q     <= '{default: '0};
         vs_q         <= 1'b1;
         frame_tick_q <= 1'b0;
      end else begin
         shadow_q     <= shadow_d;
         active_q     <= active_d;
         vs_q         <= VGA_VS;
         frame_tick_q <= commit;
      end
   end

   for (genvar g = 0; g < N_PLANETS; g++) begin : g_slot
      planet_hit_unit #(.R_W(R_W)) u_hit (
         .clk_i    (Clk),
         .rst_i    (Reset),
         .draw_x_i (DrawX),
         .draw_y_i (DrawY),
         .planet_i (active_q[g]),
         .hit_o    (hit[g])
`ifdef PLANET_RING_EN
         ,
         .ring_o   (ring[g])
`endif
      );
   end

   // Scan from the top so the lowest hitting index is assigned last.
   always_comb begin
      is_ball   = 1'b0;
      planet_id = 3'd0;
`ifdef PLANET_RING_EN
      is_ring   = 1'b0;
`endif
      for (int i = N_PLANETS - 1; i >= 0; i--) begin
         if (hit[i]) begin
            is_ball   = 1'b1;
            planet_id = 3'(i);
`ifdef PLANET_RING_EN
            is_ring   = ring[i];
`endif
         end
      end
   end

   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_planet_renderer.sv
// Directed bench for planet_renderer: reset, hit geometry, shadow/commit, priority,
// edge cases and (with PLANET_RING_EN) the outline flag.
module tb_planet_renderer;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       wr_en;
   logic [2:0] wr_idx;
   logic [31:0] wr_data;
   logic       VGA_VS;
   logic [9:0] DrawX, DrawY;
   logic       is_ball;
   logic [2:0] planet_id;
   logic       frame_tick;
`ifdef PLANET_RING_EN
   logic       is_ring;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 Clk = ~Clk;

   planet_renderer dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .wr_en      (wr_en),
      .wr_idx     (wr_idx),
      .wr_data    (wr_data),
      .VGA_VS     (VGA_VS),
      .DrawX      (DrawX),
      .DrawY      (DrawY),
      .is_ball    (is_ball),
      .planet_id  (planet_id),
      .frame_tick (frame_tick)
`ifdef PLANET_RING_EN
      ,
      .is_ring    (is_ring)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] word(input int x, input int y, input int r);
      logic [9:0] xv = 10'(x);
      logic [9:0] yv = 10'(y);
      logic [5:0] rv = 6'(r);
      return {xv, yv, rv, 6'h2a};
   endfunction

   // All tasks start and end #1 after a rising edge.
   task automatic wr(input int idx, input int x, input int y, input int r);
      wr_en   = 1'b1;
      wr_idx  = 3'(idx);
      wr_data = word(x, y, r);
      @(posedge Clk); #1;
      wr_en   = 1'b0;
   endtask

   task automatic vsync(input bit with_wr, input int idx, input int x, input int y, input int r);
      VGA_VS = 1'b0;
      if (with_wr) begin
         wr_en   = 1'b1;
         wr_idx  = 3'(idx);
         wr_data = word(x, y, r);
      end
      @(posedge Clk); #1;
      wr_en  = 1'b0;
      VGA_VS = 1'b1;
      chk("tick_on", 32'(frame_tick), 32'd1);
      @(posedge Clk); #1;
      chk("tick_off", 32'(frame_tick), 32'd0);
   endtask

   task automatic pix(input string tag, input int x, input int y, input bit ball, input int id);
      DrawX = 10'(x);
      DrawY = 10'(y);
      repeat (3) @(posedge Clk);
      #1;
      chk({tag, "_ball"}, 32'(is_ball), 32'(ball));
      chk({tag, "_id"}, 32'(planet_id), 32'(id));
   endtask

   initial begin
      Reset = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_data = '0;
      VGA_VS = 1'b1; DrawX = '0; DrawY = '0;
      repeat (2) @(posedge Clk); #1;
      chk("rst_ball", 32'(is_ball), 32'd0);
      chk("rst_id", 32'(planet_id), 32'd0);
      chk("rst_tick", 32'(frame_tick), 32'd0);
      Reset = 1'b0;
      @(posedge Clk); #1;

      // single planet, not visible before commit
      wr(0, 320, 240, 10);
      pix("precommit", 330, 240, 0, 0);
      vsync(0, 0, 0, 0, 0);
      pix("edge_r", 330, 240, 1, 0);
      pix("outside", 331, 240, 0, 0);
      pix("diag98", 327, 247, 1, 0);

      // exact three-cycle latency
      pix("lat_pre", 331, 240, 0, 0);
      DrawX = 10'd330;
      repeat (2) @(posedge Clk); #1;
      chk("lat2", 32'(is_ball), 32'd0);
      @(posedge Clk); #1;
      chk("lat3", 32'(is_ball), 32'd1);

      // shadow isolation
      wr(0, 100, 100, 5);
      pix("shadow_old", 320, 240, 1, 0);
      pix("shadow_new", 100, 100, 0, 0);
      vsync(0, 0, 0, 0, 0);
      pix("commit_new", 100, 100, 1, 0);
      pix("commit_old", 320, 240, 0, 0);

      // priority
      wr(1, 200, 200, 20);
      wr(3, 205, 200, 20);
      vsync(0, 0, 0, 0, 0);
      pix("prio_1", 205, 200, 1, 1);
      wr(1, 200, 200, 0);
      vsync(0, 0, 0, 0, 0);
      pix("prio_3", 205, 200, 1, 3);

      // out-of-range slot index
      wr(5, 500, 400, 10);
      vsync(0, 0, 0, 0, 0);
      pix("idx5_nohit", 500, 400, 0, 0);
      pix("idx5_keep", 205, 200, 1, 3);

      // write coincident with commit edge
      vsync(1, 2, 50, 50, 4);
      pix("coinc_ctr", 50, 50, 1, 2);
      pix("coinc_edge", 54, 50, 1, 2);

      // back-to-back writes, corner planet, no wrap
      wr(0, 300, 300, 3);
      wr(0, 0, 0, 8);
      vsync(0, 0, 0, 0, 0);
      pix("corner_hit", 0, 8, 1, 0);
      pix("corner_far", 639, 479, 0, 0);
      pix("corner_out", 0, 9, 0, 0);
      pix("b2b_lost", 300, 300, 0, 0);

`ifdef PLANET_RING_EN
      wr(0, 320, 240, 10);
      vsync(0, 0, 0, 0, 0);
      pix("ring_edge", 330, 240, 1, 0);
      chk("ring_edge_r", 32'(is_ring), 32'd1);
      pix("ring_ctr", 320, 240, 1, 0);
      chk("ring_ctr_r", 32'(is_ring), 32'd0);
`endif

      // reset mid-stream while planet 3 is the winner
      pix("pre_rst", 205, 200, 1, 3);
      Reset = 1'b1;
      #1;
      chk("mid_rst_ball", 32'(is_ball), 32'd0);
      chk("mid_rst_id", 32'(planet_id), 32'd0);
      chk("mid_rst_tick", 32'(frame_tick), 32'd0);
      @(posedge Clk); #1;
      Reset = 1'b0;
      vsync(0, 0, 0, 0, 0);
      pix("post_rst", 205, 200, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
